lsu_aligned: RTL
================

Name: lsu_aligned

Overview:
- Second-generation load/store unit between decode/execute and the data cache.
- Accepts one memory operation at a time over a valid/ready handshake.
- Handles sub-word accesses: derives byte enables from the address offset, lane-shifts write data, and extracts plus sign/zero-extends read data.
- Detects misaligned accesses and cache timeouts, and reports them as errors instead of issuing or hanging.

Parameters:
- DATA_WIDTH, 32, datapath width in bits; legal values 32 or 64.
- BYTE_DATA_WIDTH, DATA_WIDTH/8, number of byte lanes.
- OFFSET_BITS, log2(BYTE_DATA_WIDTH), address bits selecting the byte lane.
- TIMEOUT_CYCLES, 256, maximum cycles data_req waits for data_valid before error; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- mem_req  input  1  operation request (valid)
- mem_ready  output  1  unit can accept a request this cycle
- mem_we  input  1  1=store, 0=load
- mem_size  input  2  0=byte, 1=half, 2=word, 3=double
- mem_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- mem_addr  input  DATA_WIDTH  byte address
- mem_wdata  input  DATA_WIDTH  store data, LSB-justified
- mem_valid  output  1  one-cycle completion pulse
- mem_error  output  1  qualifies mem_valid: 1=misaligned, illegal size or timeout
- result_data  output  DATA_WIDTH  extended load result; 0 for stores and errors
- data_req  output  1  cache request, held until data_valid
- data_addr  output  DATA_WIDTH  latched address with offset bits cleared
- data_we  output  1  latched store flag
- byte_enable  output  BYTE_DATA_WIDTH  lane enables
- wdata  output  DATA_WIDTH  lane-shifted store data
- data_valid  input  1  cache completion, single cycle
- rdata  input  DATA_WIDTH  cache read data, full line word

Behaviour:
- Reset:
  - state=S_IDLE.
  - mem_ready=1; mem_valid=0; mem_error=0; data_req=0; data_we=0.
  - byte_enable=0; result_data=0; data_addr=0; wdata=0; timeout counter=0.
- States: S_IDLE, S_ACCESS, S_RESP.
- S_IDLE:
  - mem_ready=1.
  - On mem_req: latch we, size, unsigned, addr and wdata.
  - Error check: error if addr[size-1:0]!=0 (size>0), or size=3 with DATA_WIDTH=32.
  - Error path: go to S_RESP with error flag set; data_req is never asserted.
  - Otherwise go to S_ACCESS.
- S_ACCESS:
  - mem_ready=0; data_req=1.
  - data_addr = latched addr with OFFSET_BITS LSBs zeroed.
  - byte_enable = ((1<<(1<<size))-1) << offset.
  - wdata = latched wdata << (8*offset); lanes outside byte_enable are don't-care.
  - Counter increments each cycle.
  - On data_valid:
    - register result_data: rdata >> (8*offset), truncated to the access size, then extended per mem_unsigned; stores give 0.
    - go to S_RESP.
  - If counter reaches TIMEOUT_CYCLES-1 without data_valid: drop data_req, set error, go to S_RESP. A data_valid arriving after the timeout is ignored.
  - data_valid in the same cycle as the timeout: data_valid wins.
- S_RESP:
  - mem_valid=1 and mem_error=error flag for exactly one cycle; mem_ready=0.
  - Next state S_IDLE; counter and error flag cleared.
- Latency:
  - Request accepted at T gives data_req at T+1.
  - data_valid at T+1+k gives mem_valid at T+2+k.
  - Misaligned request at T gives mem_valid and mem_error at T+1.
- Back-to-back: a new request is accepted one cycle after mem_valid (S_IDLE). mem_req while mem_ready=0 is not accepted; the requester holds it.
- data_valid in S_IDLE or S_RESP is ignored.
- Reset mid-operation: all outputs return to reset values the next cycle; a pending access is abandoned; the cache must tolerate a dropped data_req.
- Outputs are registered; inputs are sampled only at acceptance.

Test Plan:
- Word load, aligned: addr=0x100, size=2, rdata=0xDEADBEEF, data_valid 3 cycles after data_req -> byte_enable=0xF, data_addr=0x100, result_data=0xDEADBEEF, mem_valid 1 cycle after data_valid, mem_error=0.
- Signed/unsigned byte load: addr=0x103, rdata=0x80112233. Signed -> byte_enable=0x8, result_data=0xFFFFFF80. Unsigned -> result_data=0x00000080.
- Half store: addr=0x102, size=1, wdata=0x0000ABCD -> data_we=1, byte_enable=0xC, wdata[31:16]=0xABCD, data_addr=0x100; mem_valid with result_data=0.
- Misaligned: word at 0x101, and half at 0x103 -> data_req never asserts; mem_valid=1 and mem_error=1 on the next cycle.
- Timeout: TIMEOUT_CYCLES=4, no data_valid -> data_req high exactly 4 cycles, then mem_valid=1 and mem_error=1; a late data_valid is ignored.
- Reset and DATA_WIDTH=64:
  - rst asserted while in S_ACCESS -> data_req=0 and mem_ready=1 the next cycle.
  - 64-bit build, double load at 0x108 -> byte_enable=0xFF.
  - 32-bit build, size=3 -> mem_error=1.

Source files
------------

// File: rtl/lsu_aligned.sv
// lsu_aligned: single-outstanding load/store unit with lane steering, load extension, misalignment and timeout errors
module lsu_aligned #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = DATA_WIDTH/8,
  parameter int OFFSET_BITS     = $clog2(BYTE_DATA_WIDTH),
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_req,
  output logic                       mem_ready,
  input  logic                       mem_we,
  input  logic [1:0]                 mem_size,
  input  logic                       mem_unsigned,
  input  logic [DATA_WIDTH-1:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic                       mem_valid,
  output logic                       mem_error,
  output logic [DATA_WIDTH-1:0]      result_data,
  output logic                       data_req,
  output logic [DATA_WIDTH-1:0]      data_addr,
  output logic                       data_we,
  output logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  output logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       data_valid,
  input  logic [DATA_WIDTH-1:0]      rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] size_q;
  logic uns_q;
  logic [OFFSET_BITS-1:0] off_q, off;
  logic [BYTE_DATA_WIDTH-1:0] be_base;
  logic [DATA_WIDTH-1:0] sh, ext;
  logic bad, sign, timeout;
  int nbytes, nbits;
  always_comb begin
    off = mem_addr[OFFSET_BITS-1:0];
    nbytes = 1 << mem_size;
    bad = nbytes > BYTE_DATA_WIDTH || (off & OFFSET_BITS'(nbytes - 1)) != '0;
    for (int i = 0; i < BYTE_DATA_WIDTH; i++) be_base[i] = i < nbytes;
    sh = rdata >> {off_q, 3'b000};
    nbits = 8 << size_q;
    sign = ~uns_q & (size_q == 2'd0 ? sh[7] : size_q == 2'd1 ? sh[15] : size_q == 2'd2 ? sh[31] : sh[DATA_WIDTH-1]);
    for (int i = 0; i < DATA_WIDTH; i++) ext[i] = i < nbits ? sh[i] : sign;
    timeout = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      off_q <= '0;
      mem_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_error <= 1'b0;
      result_data <= '0;
      data_req <= 1'b0;
      data_addr <= '0;
      data_we <= 1'b0;
      byte_enable <= '0;
      wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (mem_req) begin
          mem_ready <= 1'b0;
          size_q <= mem_size;
          uns_q <= mem_unsigned;
          off_q <= off;
          data_we <= mem_we;
          data_addr <= {mem_addr[DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          byte_enable <= be_base << off;
          wdata <= mem_wdata << {off, 3'b000};
          cnt <= '0;
          result_data <= '0;
          if (bad) begin
            state <= S_RESP;
            mem_valid <= 1'b1;
            mem_error <= 1'b1;
          end else begin
            state <= S_ACCESS;
            data_req <= 1'b1;
          end
        end
        S_ACCESS: begin
          cnt <= cnt + CW'(1);
          if (data_valid) begin
            data_req <= 1'b0;
            mem_valid <= 1'b1;
            result_data <= data_we ? '0 : ext;
            state <= S_RESP;
          end else if (timeout) begin
            data_req <= 1'b0;
            mem_valid <= 1'b1;
            mem_error <= 1'b1;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          mem_valid <= 1'b0;
          mem_error <= 1'b0;
          mem_ready <= 1'b1;
          cnt <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
